// File: rtl/trace_round_controller_pkg.sv
// rtl/trace_round_controller_pkg.sv - shared game package: FSM encoding, trace defaults, counter helper
package trace_round_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    localparam int TRACE_BITS_DEF = 16;
    localparam int MIN_ONES_DEF   = 4;
    localparam int CNT_W          = 8;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/trace_round_controller_if.sv
// rtl/trace_round_controller_if.sv - sample/handshake/status bundle between the game logic and the trace controller
interface trace_round_controller_if
    import trace_round_controller_pkg::*;
#(
    parameter int TRACE_BITS = TRACE_BITS_DEF
);
    logic                  tick;
    logic                  RBG;
    logic                  start;
    logic                  trace_saved;
    logic [TRACE_BITS-1:0] trace;
    logic                  save_trace;
    logic                  busy;
    logic [CNT_W-1:0]      round_count;
    logic [CNT_W-1:0]      reject_count;

    modport master (
        output tick, RBG, start, trace_saved,
        input  trace, save_trace, busy, round_count, reject_count
    );

    modport slave (
        input  tick, RBG, start, trace_saved,
        output trace, save_trace, busy, round_count, reject_count
    );
endinterface

// File: rtl/trace_popcount.sv
// rtl/trace_popcount.sv - combinational count of 1-bits in a captured trace
module trace_popcount #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CW-1:0]    count_o
);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end
endmodule

// File: rtl/trace_round_controller.sv
// rtl/trace_round_controller.sv - captures TRACE_BITS ticked random bits, rejects sparse traces, holds until acknowledged
module trace_round_controller
    import trace_round_controller_pkg::*;
#(
    parameter int TRACE_BITS = TRACE_BITS_DEF,
    parameter int MIN_ONES   = MIN_ONES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    trace_round_controller_if.slave bus
);
    localparam int            KW     = (TRACE_BITS > 1) ? $clog2(TRACE_BITS) : 1;
    localparam int            CW     = $clog2(TRACE_BITS + 1);
    localparam logic [KW-1:0] K_LAST = KW'(TRACE_BITS - 1);
    localparam logic [CW-1:0] MIN_C  = CW'(MIN_ONES);

    state_e                state_q, state_d;
    logic [TRACE_BITS-1:0] trace_q, trace_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CNT_W-1:0]      round_q, round_d;
    logic [CNT_W-1:0]      reject_q, reject_d;
    logic [CW-1:0]         ones;

    trace_popcount #(
        .WIDTH (TRACE_BITS),
        .CW    (CW)
    ) u_popcount (
        .bits_i  (trace_q),
        .count_o (ones)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            trace_q  <= '0;
            k_q      <= '0;
            round_q  <= '0;
            reject_q <= '0;
        end else begin
            state_q  <= state_d;
            trace_q  <= trace_d;
            k_q      <= k_d;
            round_q  <= round_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        trace_d  = trace_q;
        k_d      = k_q;
        round_d  = round_q;
        reject_d = reject_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CAPTURE;
                    trace_d = '0;
                    k_d     = '0;
                end
            end
            ST_CAPTURE: begin
                if (bus.tick) begin
                    trace_d[k_q] = bus.RBG;
                    // The final bit parks k at 0 rather than letting it wrap past the top.
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = ST_CHECK;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (ones >= MIN_C) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d  = ST_CAPTURE;
                    trace_d  = '0;
                    k_d      = '0;
                    reject_d = sat_inc(reject_q);
                end
            end
            ST_HOLD: begin
                if (bus.trace_saved) begin
                    state_d = ST_IDLE;
                    round_d = sat_inc(round_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.trace        = trace_q;
    assign bus.save_trace   = (state_q == ST_HOLD);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.round_count  = round_q;
    assign bus.reject_count = reject_q;

endmodule

// File: tb/tb_trace_round_controller.sv
// tb/tb_trace_round_controller.sv - randomized scoreboard bench for trace_round_controller
module tb_trace_round_controller;

    logic clk;
    logic reset;

    trace_round_controller_if #(.TRACE_BITS(16)) bus ();

    trace_round_controller #(
        .TRACE_BITS (16),
        .MIN_ONES   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tr;
        logic [7:0]  rej;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rej_list[$];
    int          tests;
    int          fails;
    int          exp_round;
    int          exp_rej;
    logic [15:0] held;
    bit          prev_save;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [15:0] rand_reject();
        logic [15:0] w;
        w = '0;
        repeat ($urandom_range(0, 3)) w[$urandom_range(0, 15)] = 1'b1;
        return w;
    endfunction

    function automatic logic [15:0] rand_accept();
        logic [15:0] w;
        do w = 16'($urandom); while ($countones(w) < 4);
        return w;
    endfunction

    // Scoreboard monitor: pops an expectation each time a trace is presented.
    always @(negedge clk) begin
        if (bus.save_trace && !prev_save) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_present: got trace %0h expected none", bus.trace);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("present_trace", 32'(bus.trace), 32'(e.tr));
                chk("present_reject_count", 32'(bus.reject_count), 32'(e.rej));
            end
            held = bus.trace;
        end else if (bus.save_trace) begin
            chk("hold_stable", 32'(bus.trace), 32'(held));
        end
        prev_save = bus.save_trace;
    end

    task automatic send_word(input logic [15:0] w, input bit noise, input bit fast);
        for (int b = 0; b < 16; b++) begin
            repeat (fast ? 0 : $urandom_range(0, 2)) begin
                bus.tick        = 1'b0;
                bus.RBG         = 1'($urandom);
                bus.start       = noise ? 1'($urandom) : 1'b0;
                bus.trace_saved = noise ? 1'($urandom) : 1'b0;
                step();
            end
            bus.tick        = 1'b1;
            bus.RBG         = w[b];
            bus.start       = noise ? 1'($urandom) : 1'b0;
            bus.trace_saved = noise ? 1'($urandom) : 1'b0;
            step();
        end
        bus.tick        = 1'b0;
        bus.start       = 1'b0;
        bus.trace_saved = 1'b0;
        step();
    endtask

    task automatic run_round(input logic [15:0] acc, input bit noise, input int hold,
                             input bit ack_with_start, input bit fast);
        exp_t e;
        int   w;
        exp_rej = sat(exp_rej + rej_list.size());
        e.tr    = acc;
        e.rej   = 8'(exp_rej);
        exp_q.push_back(e);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        foreach (rej_list[i]) send_word(rej_list[i], noise, fast);
        send_word(acc, noise, fast);

        w = 0;
        @(negedge clk);
        while (!bus.save_trace && w < 4) begin
            @(negedge clk);
            w++;
        end
        if (!bus.save_trace) begin
            tests++;
            fails++;
            $display("FAIL wait_present: got save_trace 0 expected 1 within 4 cycles");
        end
        if (!fast) chk("busy_in_hold", 32'(bus.busy), 32'd1);

        repeat (hold) begin
            bus.start = noise ? 1'($urandom) : 1'b0;
            step();
        end
        bus.start       = ack_with_start;
        bus.trace_saved = 1'b1;
        step();
        bus.start       = 1'b0;
        bus.trace_saved = 1'b0;
        exp_round       = sat(exp_round + 1);
        @(negedge clk);
        if (!fast) begin
            chk("ack_busy", 32'(bus.busy), 32'd0);
            chk("ack_save_trace", 32'(bus.save_trace), 32'd0);
            chk("ack_reject_count", 32'(bus.reject_count), 32'(exp_rej));
        end
        chk("ack_round_count", 32'(bus.round_count), 32'(exp_round));
        if (ack_with_start) begin
            step();
            @(negedge clk);
            chk("start_with_ack_ignored", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; exp_round = 0; exp_rej = 0; prev_save = 1'b0; held = '0;
        reset = 1'b1;
        bus.tick = 1'b0; bus.RBG = 1'b0; bus.start = 1'b0; bus.trace_saved = 1'b0;
        step(); step();
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_save_trace", 32'(bus.save_trace), 32'd0);
        chk("reset_trace", 32'(bus.trace), 32'd0);
        chk("reset_round_count", 32'(bus.round_count), 32'd0);
        chk("reset_reject_count", 32'(bus.reject_count), 32'd0);
        reset = 1'b0;

        bus.trace_saved = 1'b1;
        step();
        bus.trace_saved = 1'b0;
        @(negedge clk);
        chk("idle_ack_ignored_busy", 32'(bus.busy), 32'd0);
        chk("idle_ack_ignored_round", 32'(bus.round_count), 32'd0);

        rej_list = {};
        run_round(16'hFFFF, 1'b0, 0, 1'b0, 1'b0);
        rej_list = {16'h0007};
        run_round(16'h00FF, 1'b0, 2, 1'b0, 1'b0);
        rej_list = {};
        run_round(16'h000F, 1'b0, 0, 1'b1, 1'b0);
        rej_list = {16'h0007, 16'h8001};
        run_round(16'hF000, 1'b0, 1, 1'b0, 1'b0);

        // Reset mid-capture drops the partial trace and both counters.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bus.tick = 1'b1;
            bus.RBG  = 1'b1;
            step();
        end
        bus.tick = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        chk("pre_reset_partial", 32'(bus.trace), 32'h00FF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_busy", 32'(bus.busy), 32'd0);
        chk("mid_reset_trace", 32'(bus.trace), 32'd0);
        chk("mid_reset_round", 32'(bus.round_count), 32'd0);
        chk("mid_reset_reject", 32'(bus.reject_count), 32'd0);
        exp_round = 0;
        exp_rej   = 0;
        rej_list  = {};
        run_round(rand_accept(), 1'b0, 0, 1'b0, 1'b0);

        rej_list = {16'h0001};
        run_round(16'h1111, 1'b1, 10, 1'b1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            rej_list = {};
            repeat ($urandom_range(0, 2)) rej_list.push_back(rand_reject());
            run_round(rand_accept(), 1'b1, $urandom_range(0, 4), 1'($urandom), 1'b0);
        end

        rej_list = {};
        for (int r = 0; r < 256; r++) begin
            run_round(16'hFFFF, 1'b0, 0, 1'b0, 1'b1);
        end
        chk("round_saturated", 32'(bus.round_count), 32'd255);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trace_round_controller.md
TRACE_ROUND_CONTROLLER -- requirements
Module: trace_round_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter TRACE_BITS, 16: number of random bits captured per trace.
REQ-003 Parameter MIN_ONES, 4: minimum count of 1-bits for a trace to be accepted.
REQ-004 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port tick  input  1  one-clk-wide sample strobe (5 Hz rate, from the existing divider).
REQ-007 Port RBG  input  1  random bit source, sampled only when tick=1 in CAPTURE.
REQ-008 Port start  input  1  request a new trace round.
REQ-009 Port trace_saved  input  1  consumer acknowledge of the presented trace.
REQ-010 Port trace  output  TRACE_BITS  captured trace, bit k = k-th accepted sample.
REQ-011 Port save_trace  output  1  trace valid; high only in HOLD.
REQ-012 Port busy  output  1  high in CAPTURE, CHECK and HOLD.
REQ-013 Port round_count  output  8  number of acknowledged traces since reset.
REQ-014 Port reject_count  output  8  number of traces discarded for too few 1-bits.

Function
REQ-015 The block SHALL implement states IDLE, CAPTURE, CHECK, HOLD.
REQ-016 IDLE: start=1 -> CAPTURE next cycle; trace cleared to 0; bit index k cleared to 0.
REQ-017 CAPTURE: on each cycle with tick=1, trace[k] <= RBG and k <= k+1; cycles with tick=0 SHALL change nothing.
REQ-018 CAPTURE: the tick that writes bit TRACE_BITS-1 SHALL move the FSM to CHECK on the same edge; k SHALL never exceed TRACE_BITS-1 (no wrap write).
REQ-019 CHECK lasts exactly one cycle: popcount(trace) >= MIN_ONES -> HOLD; otherwise -> CAPTURE with k=0, trace=0, reject_count+1.
REQ-020 HOLD: save_trace=1 and trace held stable; trace_saved=1 -> IDLE next cycle, round_count+1, save_trace=0 in IDLE.
REQ-021 Latency: from start to save_trace SHALL be 1 + (cycles to collect TRACE_BITS ticks) + 1 clk, plus one full recapture per rejection.
REQ-022 start SHALL be ignored outside IDLE; trace_saved SHALL be ignored outside HOLD.
REQ-023 When start and trace_saved are both high in HOLD, only the acknowledge SHALL take effect; a new round requires start in IDLE.
REQ-024 round_count and reject_count SHALL saturate at 255 and not wrap.
REQ-025 tick and RBG SHALL be treated as already synchronous to clk.

Reset
REQ-026 reset=1 SHALL, on the next clk edge and from any state, force IDLE, trace=0, k=0, save_trace=0, busy=0, round_count=0, reject_count=0.
REQ-027 Reset during CAPTURE or HOLD SHALL discard the partial or pending trace without an acknowledge being required.
REQ-028 reset SHALL take priority over every other input in the same cycle.

Structure
REQ-029 The state encoding, TRACE_BITS and MIN_ONES defaults SHALL live in the shared game package.
REQ-030 The popcount SHALL be one combinational sub-module, trace_popcount, taking TRACE_BITS bits and returning a $clog2(TRACE_BITS+1)-bit count.
REQ-031 The block SHALL NOT instantiate the frequency divider; tick comes from outside.

Verification
REQ-032 Directed test: reset, start, 16 ticks with RBG=1 -> CHECK, then save_trace=1 with trace=16'hFFFF; after trace_saved, round_count=1 and state=IDLE.
REQ-033 Directed test: RBG pattern with 3 ones (trace=16'h0007) -> reject_count=1, CAPTURE restarts at k=0; then 16'h00FF -> accepted and presented.
REQ-034 Directed test: exactly MIN_ONES ones (16'h000F) -> accepted; 3 ones -> rejected (boundary check).
REQ-035 Directed test: reset asserted after 8 ticks -> next cycle IDLE, trace=0, busy=0; start then captures a fresh 16 bits.
REQ-036 Directed test: start pulses during CAPTURE and HOLD, and trace_saved outside HOLD -> no state or counter change; trace stable across 10 HOLD cycles with trace_saved=0.
REQ-037 Directed test: 256 acknowledged rounds -> round_count holds at 255.
